// File: rtl/pixel_window_buffer.sv
// pixel_window_buffer
// Row-window shift buffer feeding the sub-pixel interpolation filter array.
// Holds the last DEPTH rows of ROW_PIX pixels and presents them as one flat
// bus, row-major or column-major. Rows enter through a valid/ready port.
// A full window is offered through a second valid/ready port. STRIDE new
// rows are required between consecutive windows. Input is stalled while a
// window is on offer, so win_data stays stable until it is consumed.

module pixel_window_buffer #(
  parameter int PIX_W     = 8,
  parameter int ROW_PIX   = 8,
  parameter int DEPTH     = 15,
  parameter int STRIDE    = 1,
  parameter int TRANSPOSE = 1,
  parameter int CNT_W     = 4
) (
  input  logic                           clock,
  input  logic                           reset_L,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROW_PIX*PIX_W-1:0]       in_data,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [DEPTH*ROW_PIX*PIX_W-1:0] win_data,
  output logic [CNT_W-1:0]               fill_cnt
);

  localparam int ROW_W = ROW_PIX * PIX_W;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // Reject parameter sets the buffer cannot represent
  if (DEPTH < 2) begin : g_bad_depth
    $error("pixel_window_buffer: DEPTH must be at least 2");
  end
  if ((STRIDE < 1) || (STRIDE > DEPTH)) begin : g_bad_stride
    $error("pixel_window_buffer: STRIDE must lie in 1..DEPTH");
  end
  if (CNT_W < $clog2(DEPTH + 1)) begin : g_bad_cnt_w
    $error("pixel_window_buffer: CNT_W too narrow to count DEPTH rows");
  end

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_VALID   = 2'd1,
    ST_ADVANCE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] fill_cnt_nxt;
  logic [CNT_W-1:0] adv_cnt;
  logic [CNT_W-1:0] adv_cnt_nxt;
  logic [ROW_W-1:0] rows [DEPTH];
  logic             accept;
  logic             take;

  // Handshake flags come straight from the state register. During a flush
  // cycle they therefore still show the pre-flush state.
  assign in_ready  = (state != ST_VALID);
  assign win_valid = (state == ST_VALID);
  assign accept    = in_valid && in_ready;
  assign take      = win_valid && win_ready;

  // Next-state, fill and stride counters. A flush overrides everything.
  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    adv_cnt_nxt  = adv_cnt;

    if (accept && (fill_cnt != DEPTH_C)) begin
      fill_cnt_nxt = fill_cnt + ONE_C;
    end

    case (state)
      ST_FILL: begin
        if (accept && (fill_cnt == (DEPTH_C - ONE_C))) begin
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (take) begin
          state_nxt   = ST_ADVANCE;
          adv_cnt_nxt = '0;
        end
      end
      ST_ADVANCE: begin
        if (accept) begin
          adv_cnt_nxt = adv_cnt + ONE_C;
          if (adv_cnt == (STRIDE_C - ONE_C)) begin
            state_nxt = ST_VALID;
          end
        end
      end
      default: begin
        state_nxt   = ST_FILL;
        adv_cnt_nxt = '0;
      end
    endcase

    if (flush) begin
      state_nxt    = ST_FILL;
      fill_cnt_nxt = '0;
      adv_cnt_nxt  = '0;
    end
  end

  // Control registers: state, fill count and stride count
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      adv_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      adv_cnt  <= adv_cnt_nxt;
    end
  end

  // Row storage: shift toward row 0 on each accepted row, newest at DEPTH-1
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int r = 0; r < DEPTH; r++) begin
        rows[r] <= '0;
      end
    end else if (flush) begin
      for (int r = 0; r < DEPTH; r++) begin
        rows[r] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < DEPTH - 1; r++) begin
        rows[r] <= rows[r+1];
      end
      rows[DEPTH-1] <= in_data;
    end
  end

  // Window bus: pure wiring from the row registers, no added latency
  for (genvar gr = 0; gr < DEPTH; gr++) begin : g_row
    for (genvar gc = 0; gc < ROW_PIX; gc++) begin : g_col
      if (TRANSPOSE != 0) begin : g_col_major
        assign win_data[(gc*DEPTH + gr)*PIX_W +: PIX_W] = rows[gr][gc*PIX_W +: PIX_W];
      end else begin : g_row_major
        assign win_data[(gr*ROW_PIX + gc)*PIX_W +: PIX_W] = rows[gr][gc*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Testbench for pixel_window_buffer.
// Three instances: defaults (15x8 bytes, transposed), STRIDE=4 row-major,
// and a small 10-bit 6x4 buffer driven with random handshake gaps.

module tb_pixel_window_buffer;

  logic clock = 1'b0;
  logic reset_L;

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: defaults ----------------
  logic         a_flush, a_in_valid, a_in_ready, a_win_valid, a_win_ready;
  logic [63:0]  a_in_data;
  logic [959:0] a_win_data;
  logic [3:0]   a_fill_cnt;

  pixel_window_buffer u_dut_a (
    .clock(clock), .reset_L(reset_L), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .win_valid(a_win_valid), .win_ready(a_win_ready), .win_data(a_win_data),
    .fill_cnt(a_fill_cnt)
  );

  // ---------------- instance B: STRIDE=4, row-major ----------------
  logic         b_flush, b_in_valid, b_in_ready, b_win_valid, b_win_ready;
  logic [63:0]  b_in_data;
  logic [959:0] b_win_data;
  logic [3:0]   b_fill_cnt;

  pixel_window_buffer #(.STRIDE(4), .TRANSPOSE(0)) u_dut_b (
    .clock(clock), .reset_L(reset_L), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .win_valid(b_win_valid), .win_ready(b_win_ready), .win_data(b_win_data),
    .fill_cnt(b_fill_cnt)
  );

  // ---------------- instance C: 10-bit, 4 pixels, 6 rows ----------------
  logic         c_flush, c_in_valid, c_in_ready, c_win_valid, c_win_ready;
  logic [39:0]  c_in_data;
  logic [239:0] c_win_data;
  logic [3:0]   c_fill_cnt;

  pixel_window_buffer #(.PIX_W(10), .ROW_PIX(4), .DEPTH(6)) u_dut_c (
    .clock(clock), .reset_L(reset_L), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .win_valid(c_win_valid), .win_ready(c_win_ready), .win_data(c_win_data),
    .fill_cnt(c_fill_cnt)
  );

  // Reference row stores, index 0 oldest
  logic [63:0] ma [15];
  logic [63:0] mb [15];
  logic [39:0] mc [6];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] mkrow(input int k);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) begin
      r[c*8 +: 8] = 8'((k*16 + c) & 255);
    end
    return r;
  endfunction

  task automatic ma_clear();
    for (int r = 0; r < 15; r++) ma[r] = '0;
  endtask

  task automatic ma_shift(input logic [63:0] row);
    for (int r = 0; r < 14; r++) ma[r] = ma[r+1];
    ma[14] = row;
  endtask

  task automatic mb_shift(input logic [63:0] row);
    for (int r = 0; r < 14; r++) mb[r] = mb[r+1];
    mb[14] = row;
  endtask

  task automatic mc_shift(input logic [39:0] row);
    for (int r = 0; r < 5; r++) mc[r] = mc[r+1];
    mc[5] = row;
  endtask

  task automatic check_win_a(input string tag);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 8; c++)
        check_val($sformatf("%s a_win r%0d c%0d", tag, r, c),
                  64'(a_win_data[(c*15 + r)*8 +: 8]), 64'(ma[r][c*8 +: 8]));
  endtask

  task automatic check_win_b(input string tag);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 8; c++)
        check_val($sformatf("%s b_win r%0d c%0d", tag, r, c),
                  64'(b_win_data[(r*8 + c)*8 +: 8]), 64'(mb[r][c*8 +: 8]));
  endtask

  task automatic check_win_c(input string tag);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        check_val($sformatf("%s c_win r%0d c%0d", tag, r, c),
                  64'(c_win_data[(c*6 + r)*10 +: 10]), 64'(mc[r][c*10 +: 10]));
  endtask

  task automatic push_a(input logic [63:0] row);
    int guard = 0;
    a_in_valid = 1'b1;
    a_in_data  = row;
    while (!a_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!a_in_ready) begin
      check_val("a_push_timeout", 64'(a_in_ready), 64'd1);
      a_in_valid = 1'b0;
      return;
    end
    tick();
    ma_shift(row);
    a_in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [63:0] row);
    int guard = 0;
    b_in_valid = 1'b1;
    b_in_data  = row;
    while (!b_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!b_in_ready) begin
      check_val("b_push_timeout", 64'(b_in_ready), 64'd1);
      b_in_valid = 1'b0;
      return;
    end
    tick();
    mb_shift(row);
    b_in_valid = 1'b0;
  endtask

  // Push rows 1..15 into A, checking win_valid rises only on the 15th
  task automatic fill_a(input int base, input string tag);
    for (int k = 1; k <= 15; k++) begin
      push_a(mkrow(base + k));
      check_val($sformatf("%s fill_cnt k%0d", tag, k), 64'(a_fill_cnt), 64'(k));
      check_val($sformatf("%s win_valid k%0d", tag, k), 64'(a_win_valid), (k == 15) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] e_row;
    int  e_fill, e_adv, seq, windows;
    bit  e_valid, acc, tk;

    reset_L = 1'b0;
    a_flush = 0; a_in_valid = 0; a_win_ready = 0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_win_ready = 0; b_in_data = '0;
    c_flush = 0; c_in_valid = 0; c_win_ready = 0; c_in_data = '0;
    ma_clear();
    for (int r = 0; r < 15; r++) mb[r] = '0;
    for (int r = 0; r < 6; r++) mc[r] = '0;

    repeat (2) @(posedge clock);
    #1;
    // Reset state
    check_val("rst a_in_ready", 64'(a_in_ready), 64'd1);
    check_val("rst a_win_valid", 64'(a_win_valid), 64'd0);
    check_val("rst a_fill_cnt", 64'(a_fill_cnt), 64'd0);
    check_val("rst b_in_ready", 64'(b_in_ready), 64'd1);
    check_val("rst c_win_valid", 64'(c_win_valid), 64'd0);
    check_win_a("rst");
    reset_L = 1'b1;
    tick();

    // Test 1: first window, transposed layout
    fill_a(0, "t1");
    check_val("t1 in_ready", 64'(a_in_ready), 64'd0);
    check_val("t1 byte0", 64'(a_win_data[7:0]), 64'h10);
    check_val("t1 byte119", 64'(a_win_data[119*8 +: 8]), 64'hF7);
    check_win_a("t1");

    // Test 2: window held while input is offered
    a_in_valid = 1'b1;
    a_in_data  = {8{8'hAA}};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("t2 in_ready c%0d", i), 64'(a_in_ready), 64'd0);
      check_val($sformatf("t2 win_valid c%0d", i), 64'(a_win_valid), 64'd1);
    end
    check_win_a("t2 held");
    a_in_valid  = 1'b0;
    a_win_ready = 1'b1;
    tick();
    check_val("t2 adv win_valid", 64'(a_win_valid), 64'd0);
    check_val("t2 adv in_ready", 64'(a_in_ready), 64'd1);
    tick();
    check_val("t2 ready ignored", 64'(a_win_valid), 64'd0);
    a_win_ready = 1'b0;
    push_a({8{8'hBB}});
    check_val("t2 win_valid", 64'(a_win_valid), 64'd1);
    check_val("t2 fill_cnt", 64'(a_fill_cnt), 64'd15);
    check_val("t2 r0c0", 64'(a_win_data[7:0]), 64'h20);
    check_val("t2 r14c3", 64'(a_win_data[(3*15 + 14)*8 +: 8]), 64'hBB);
    check_win_a("t2 new");

    // Test 4: flush in ADVANCE with a concurrent input row
    a_win_ready = 1'b1;
    tick();
    a_win_ready = 1'b0;
    a_flush     = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = {8{8'hCC}};
    #1;
    check_val("t4 in_ready during flush", 64'(a_in_ready), 64'd1);
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    ma_clear();
    check_val("t4 fill_cnt", 64'(a_fill_cnt), 64'd0);
    check_val("t4 win_valid", 64'(a_win_valid), 64'd0);
    check_val("t4 in_ready", 64'(a_in_ready), 64'd1);
    check_win_a("t4 cleared");
    fill_a(32, "t4");
    check_win_a("t4 refill");

    // Flush in VALID with win_ready high: window handshake is discarded
    a_flush     = 1'b1;
    a_win_ready = 1'b1;
    #1;
    check_val("t4b win_valid during flush", 64'(a_win_valid), 64'd1);
    tick();
    a_flush     = 1'b0;
    a_win_ready = 1'b0;
    ma_clear();
    check_val("t4b win_valid", 64'(a_win_valid), 64'd0);
    check_val("t4b fill_cnt", 64'(a_fill_cnt), 64'd0);

    // Test 5: asynchronous reset pulse mid-fill
    for (int k = 1; k <= 7; k++) push_a(mkrow(k + 64));
    check_val("t5 fill_cnt 7", 64'(a_fill_cnt), 64'd7);
    #3;
    reset_L = 1'b0;
    #1;
    ma_clear();
    check_val("t5 fill_cnt", 64'(a_fill_cnt), 64'd0);
    check_val("t5 in_ready", 64'(a_in_ready), 64'd1);
    check_val("t5 win_valid", 64'(a_win_valid), 64'd0);
    check_win_a("t5 reset");
    #2;
    reset_L = 1'b1;
    tick();
    fill_a(80, "t5");

    // Test 3: STRIDE=4, row-major
    for (int k = 1; k <= 15; k++) push_b(mkrow(k));
    check_val("t3 win_valid first", 64'(b_win_valid), 64'd1);
    check_win_b("t3 first");
    b_win_ready = 1'b1;
    tick();
    b_win_ready = 1'b0;
    check_val("t3 adv win_valid", 64'(b_win_valid), 64'd0);
    for (int k = 16; k <= 19; k++) begin
      push_b(mkrow(k));
      check_val($sformatf("t3 win_valid k%0d", k), 64'(b_win_valid), (k == 19) ? 64'd1 : 64'd0);
    end
    check_val("t3 fill_cnt", 64'(b_fill_cnt), 64'd15);
    check_val("t3 byte0", 64'(b_win_data[7:0]), 64'h50);
    check_val("t3 byte119", 64'(b_win_data[119*8 +: 8]), 64'h37);
    check_win_b("t3 second");

    // Test 6: small buffer, random gaps, scoreboard
    e_fill = 0; e_adv = 0; e_valid = 0; seq = 0; windows = 0;
    for (int i = 0; i < 600; i++) begin
      check_val("t6 win_valid", 64'(c_win_valid), 64'(e_valid));
      check_val("t6 in_ready", 64'(c_in_ready), 64'(!e_valid));
      check_val("t6 fill_cnt", 64'(c_fill_cnt), 64'(e_fill));
      c_in_valid  = ($urandom_range(0, 3) != 0);
      e_row       = {30'($urandom()), 10'(seq)};
      c_in_data   = e_row;
      c_win_ready = ($urandom_range(0, 1) != 0);
      acc = c_in_valid && !e_valid;
      tk  = e_valid && c_win_ready;
      if (tk) begin
        check_win_c("t6");
        check_val("t6 newest seq", 64'(c_win_data[5*10 +: 10]), 64'(10'(seq - 1)));
        windows++;
      end
      tick();
      if (acc) begin
        mc_shift(e_row);
        seq++;
        if (e_fill < 6) begin
          e_fill++;
          if (e_fill == 6) e_valid = 1;
        end else begin
          e_adv++;
          if (e_adv == 1) e_valid = 1;
        end
      end
      if (tk) begin
        e_valid = 0;
        e_adv   = 0;
      end
    end
    c_in_valid  = 1'b0;
    c_win_ready = 1'b0;
    check_val("t6 windows seen", 64'(windows >= 20), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_window_buffer.md
Name: pixel_window_buffer

Overview:
- Parametrised row-window shift buffer. Accepts one row of ROW_PIX pixels per handshake and holds the last DEPTH rows.
- Presents the whole window as one flat bus, either row-major or transposed (column-major), to the sub-pixel interpolation filter array.
- Adds valid/ready flow control, a configurable vertical stride between windows, a synchronous flush and a fill counter.
- Generalises the fixed 15x8-byte row/transpose shift registers.

Parameters:
PIX_W, 8, bits per pixel
ROW_PIX, 8, pixels per input row
DEPTH, 15, rows held in the window (>=2)
STRIDE, 1, new rows required between consecutive windows (1..DEPTH)
TRANSPOSE, 1, 0 = row-major output, 1 = column-major output
CNT_W, 4, width of fill_cnt; must be >= clog2(DEPTH+1)

Ports:
clock  in  1  rising-edge clock
reset_L  in  1  reset; asynchronous, active-low
flush  in  1  synchronous clear of contents and state
in_valid  in  1  in_data holds a row
in_ready  out  1  buffer accepts a row this cycle
in_data  in  ROW_PIX*PIX_W  row; pixel c at [c*PIX_W +: PIX_W]
win_valid  out  1  full window available
win_ready  in  1  consumer takes the window this cycle
win_data  out  DEPTH*ROW_PIX*PIX_W  window contents
fill_cnt  out  CNT_W  rows held, saturating at DEPTH

Behaviour:
- Storage: DEPTH row registers. Row 0 is the oldest, row DEPTH-1 the newest. Rows update on rising clock edges only.
- Accept: in_valid && in_ready at an edge. All rows shift down by one (row r takes row r+1), in_data goes to row DEPTH-1, and the old row 0 is discarded.
- in_valid while in_ready=0: no shift; in_data is ignored and not captured.
- Output mapping, driven directly from the storage registers with no extra latency:
  - TRANSPOSE=0: win_data[(r*ROW_PIX+c)*PIX_W +: PIX_W] = row r, pixel c.
  - TRANSPOSE=1: win_data[(c*DEPTH+r)*PIX_W +: PIX_W] = row r, pixel c.
- State machine, three states:
  - FILL: in_ready=1, win_valid=0. Each accept increments fill_cnt. The accept that makes fill_cnt==DEPTH moves to VALID, so win_valid=1 in the cycle after that edge.
  - VALID: in_ready=0, win_valid=1. win_data is held stable until handshake. win_valid && win_ready at an edge moves to ADVANCE and clears adv_cnt.
  - ADVANCE: in_ready=1, win_valid=0. Each accept increments internal adv_cnt (0..STRIDE). The accept that makes adv_cnt==STRIDE moves to VALID.
- fill_cnt: increments on accept and saturates at DEPTH. It stays DEPTH through VALID/ADVANCE and is cleared only by reset or flush.
- Window throughput: at most one window per STRIDE+1 cycles. Input is stalled in VALID by design.
- flush, synchronous, highest priority:
  - all rows cleared to 0, fill_cnt=0, adv_cnt=0, state = FILL;
  - an input or window handshake in the same cycle is discarded;
  - in_ready and win_valid still show their pre-flush values during the flush cycle.
- Reset, asynchronous, also valid mid-operation: rows=0, fill_cnt=0, adv_cnt=0, state = FILL. Therefore in_ready=1, win_valid=0, win_data=0. Identical to flush.
- Boundaries:
  - STRIDE=DEPTH: every window consists of fully new rows.
  - win_ready held high in VALID: the window is consumed on the first VALID cycle.
  - win_ready in FILL/ADVANCE: ignored.

Test Plan:
1. Defaults. Reset, then push rows k=1..15 with pixel c = k*16+c. win_valid rises the cycle after the 15th accept, fill_cnt=15. TRANSPOSE=1 output byte (c*15+r) = (r+1)*16+c, e.g. byte 0 = 0x10 and byte 119 = 0xF7.
2. Defaults, window held. Keep win_ready=0 for 5 cycles with in_valid=1 and row 0xAA. in_ready=0 throughout and win_data is unchanged. Raise win_ready: ADVANCE, push one row 0xBB. The new window has row 14 = 0xBB and row 0 = old row 1.
3. STRIDE=4, TRANSPOSE=0. After the first window handshake, win_valid stays 0 for exactly 4 accepts and then rises. Row-major byte (r*8+c) matches the expected 15x8 array shifted by 4.
4. Flush asserted in ADVANCE while in_valid=1. Next cycle: fill_cnt=0, win_data=0, state FILL, and the concurrent row is not stored. 15 further pushes are needed before win_valid.
5. Async reset_L pulse mid-FILL (fill_cnt=7), not aligned to a clock edge. Outputs clear immediately. After release, 15 pushes are needed for win_valid.
6. PIX_W=10, ROW_PIX=4, DEPTH=6. Random rows with random in_valid/win_ready gaps. A scoreboard checks every window against a model, and that no row is lost or duplicated.
